// File: rtl/id_stage_ctrl.sv
// Decode stage behind the IF/ID register. It decodes the instruction, reads the register file
// with a WB bypass, resolves BEQ, drives the IF-side stall/flush controls and holds the ID/EX register.
module id_stage_ctrl #(
    parameter int DW       = 32,
    parameter bit RF_CLEAR = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] Next_Address_in,
    input  logic [31:0]   Instruction_in,
    input  logic          mem_RegWrite,
    input  logic [4:0]    mem_WReg,
    input  logic          wb_RegWrite,
    input  logic [4:0]    wb_WReg,
    input  logic [DW-1:0] wb_Data,
    output logic          PCWrite,
    output logic          hzdetect,
    output logic          freeze,
    output logic          flush,
    output logic          PCSrc,
    output logic [DW-1:0] Branch_Address,
    output logic [6:0]    idex_Ctrl,
    output logic [DW-1:0] idex_RD1,
    output logic [DW-1:0] idex_RD2,
    output logic [DW-1:0] idex_Imm,
    output logic [4:0]    idex_Rs,
    output logic [4:0]    idex_Rt,
    output logic [4:0]    idex_Rd,
    output logic [5:0]    idex_Funct
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Control word bits: {RegWrite, MemRead, MemWrite, ALUSrc, RegDst, ALUOp[1:0]}
    localparam int CB_REGWRITE = 6;
    localparam int CB_MEMREAD  = 5;
    localparam int CB_REGDST   = 2;

    logic [5:0]    opcode;
    logic [4:0]    rs, rt, rd;
    logic [5:0]    funct;
    logic [DW-1:0] imm_ext;

    assign opcode  = Instruction_in[31:26];
    assign rs      = Instruction_in[25:21];
    assign rt      = Instruction_in[20:16];
    assign rd      = Instruction_in[15:11];
    assign funct   = Instruction_in[5:0];
    assign imm_ext = {{(DW-16){Instruction_in[15]}}, Instruction_in[15:0]};

    logic [6:0] ctrl_dec;
    logic       uses_rs, uses_rt, is_beq;

    // NOTE: every signal written in always_comb gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        ctrl_dec = '0;
        uses_rs  = 1'b0;
        uses_rt  = 1'b0;
        is_beq   = 1'b0;
        if (Instruction_in != '0) begin
            unique case (opcode)
                OP_RTYPE: begin ctrl_dec = 7'b1000110; uses_rs = 1'b1; uses_rt = 1'b1; end
                OP_LW:    begin ctrl_dec = 7'b1101000; uses_rs = 1'b1; end
                OP_SW:    begin ctrl_dec = 7'b0011000; uses_rs = 1'b1; uses_rt = 1'b1; end
                OP_ADDI:  begin ctrl_dec = 7'b1001000; uses_rs = 1'b1; end
                OP_BEQ:   begin uses_rs = 1'b1; uses_rt = 1'b1; is_beq = 1'b1; end
                default:  ;
            endcase
        end
    end

    logic [DW-1:0] rf [32];
    logic          rf_we;

    assign rf_we = wb_RegWrite && (wb_WReg != 5'd0);

    // NOTE: the register file is only cleared when RF_CLEAR is set; otherwise it has no reset
    // so it can map onto plain RAM without a reset port.
    generate
        if (RF_CLEAR) begin : g_rf_clear
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < 32; i++) rf[i] <= '0;
                end else if (rf_we) begin
                    rf[wb_WReg] <= wb_Data;
                end
            end
        end else begin : g_rf_noclear
            always_ff @(posedge clk) begin
                if (rf_we) rf[wb_WReg] <= wb_Data;
            end
        end
    endgenerate

    logic [DW-1:0] rd1, rd2;

    // WB write data is forwarded in the same cycle, so ID never sees the stale entry.
    always_comb begin
        rd1 = rf[rs];
        rd2 = rf[rt];
        if (rs == 5'd0)                         rd1 = '0;
        else if (rf_we && (wb_WReg == rs))      rd1 = wb_Data;
        if (rt == 5'd0)                         rd2 = '0;
        else if (rf_we && (wb_WReg == rt))      rd2 = wb_Data;
    end

    logic [6:0]    ctrl_q, ctrl_d;
    logic [DW-1:0] rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
    logic [4:0]    rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic [5:0]    funct_q, funct_d;

    logic [4:0] ex_dest;
    logic       ex_valid, stall_a, stall_b, stall, mem_valid;

    assign ex_dest   = ctrl_q[CB_REGDST] ? rd_q : rt_q;
    assign ex_valid  = ctrl_q[CB_REGWRITE] && (ex_dest != 5'd0);
    assign mem_valid = mem_RegWrite && (mem_WReg != 5'd0);

    assign stall_a = ctrl_q[CB_MEMREAD] && (rt_q != 5'd0) &&
                     ((uses_rs && (rt_q == rs)) || (uses_rt && (rt_q == rt)));
    assign stall_b = is_beq &&
                     ((ex_valid  && ((ex_dest  == rs) || (ex_dest  == rt))) ||
                      (mem_valid && ((mem_WReg == rs) || (mem_WReg == rt))));
    assign stall   = stall_a || stall_b;

    assign PCWrite        = !stall;
    assign hzdetect       = stall;
    assign freeze         = stall;
    assign PCSrc          = is_beq && !stall && (rd1 == rd2);
    assign flush          = PCSrc;
    assign Branch_Address = Next_Address_in + {imm_ext[DW-3:0], 2'b00};

    // Stalls and branches resolved here both send an all-zero bubble down to EX.
    always_comb begin
        ctrl_d  = '0;
        rd1_d   = '0;
        rd2_d   = '0;
        imm_d   = '0;
        rs_d    = '0;
        rt_d    = '0;
        rd_d    = '0;
        funct_d = '0;
        if (!stall && !is_beq) begin
            ctrl_d  = ctrl_dec;
            rd1_d   = rd1;
            rd2_d   = rd2;
            imm_d   = imm_ext;
            rs_d    = rs;
            rt_d    = rt;
            rd_d    = rd;
            funct_d = funct;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q  <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            funct_q <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            imm_q   <= imm_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            funct_q <= funct_d;
        end
    end

    assign idex_Ctrl  = ctrl_q;
    assign idex_RD1   = rd1_q;
    assign idex_RD2   = rd2_q;
    assign idex_Imm   = imm_q;
    assign idex_Rs    = rs_q;
    assign idex_Rt    = rt_q;
    assign idex_Rd    = rd_q;
    assign idex_Funct = funct_q;

endmodule
